// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: fill FSM state encoding and block geometry.
package cache_fill_fsm_pkg;

    // Fill controller state encoding, shared with the cache controller.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // 16-bit words fetched per cache block.
    localparam int unsigned CACHE_WORDS_PER_BLOCK = 8;

    // Width of the word offset within a block.
    localparam int unsigned CACHE_WORD_OFF_W = $clog2(CACHE_WORDS_PER_BLOCK);

    // Width of the byte offset within a block (16-byte blocks).
    localparam int unsigned CACHE_BYTE_OFF_W = 4;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/fill handshake bundle between the cache, main memory and the fill FSM.
interface cache_fill_fsm_if
    import cache_fill_fsm_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = CACHE_WORDS_PER_BLOCK,
    parameter int ADDR_W          = 16
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic [15:0]       memory_data;
    logic              fsm_busy;
    logic              memory_req;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [15:0]       fill_data;
    logic [OFF_W-1:0]  fill_word;
    logic              write_tag_array;

    // Cache/memory side: reports misses, returns data, consumes fill commands.
    modport master (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, memory_req, memory_address, write_data_array,
               fill_data, fill_word, write_tag_array
    );

    // Fill FSM side.
    modport slave (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, memory_req, memory_address, write_data_array,
               fill_data, fill_word, write_tag_array
    );

endinterface

// File: rtl/cache_fill_fsm_word_counter.sv
// Resettable up-counter with synchronous clear (priority) and enable.
module word_counter
    import cache_fill_fsm_pkg::*;
#(
    parameter int W = CACHE_WORD_OFF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count enabled cycles; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: issues one word read per cycle for the missing
// block and writes returned words into the data array, tagging on the last.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = CACHE_WORDS_PER_BLOCK,
    parameter int ADDR_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    cache_fill_fsm_if.slave  bus
);

    localparam int OFF_W      = $clog2(WORDS_PER_BLOCK);
    localparam int BYTE_OFF_W = CACHE_BYTE_OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_BLOCK - 1);

    fill_state_e       state;
    logic [ADDR_W-1:0] base;
    logic              issue_done;
    logic [OFF_W-1:0]  issue_cnt;
    logic [OFF_W-1:0]  recv_cnt;

    logic              in_fill;
    logic              issue_fire;
    logic              recv_fire;
    logic              last_recv;
    logic [ADDR_W-1:0] aligned_miss;

    // The counter cannot represent WORDS_PER_BLOCK itself, so issue_done marks
    // that all requests went out while issue_cnt wraps back to zero.
    assign in_fill      = (state == FILL);
    assign issue_fire   = in_fill && !issue_done;
    assign recv_fire    = in_fill && bus.memory_data_valid;
    assign last_recv    = recv_fire && (recv_cnt == LAST_WORD);
    assign aligned_miss = {bus.miss_address[ADDR_W-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};

    word_counter #(.W(OFF_W)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (issue_fire),
        .clr   (last_recv),
        .count (issue_cnt)
    );

    word_counter #(.W(OFF_W)) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (recv_fire),
        .clr   (last_recv),
        .count (recv_cnt)
    );

    // State, block base and issue-complete flag; a miss seen on the final
    // receive restarts the fill at once with no idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            issue_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_detected) begin
                        state      <= FILL;
                        base       <= aligned_miss;
                        issue_done <= 1'b0;
                    end
                end
                FILL: begin
                    if (last_recv) begin
                        issue_done <= 1'b0;
                        if (bus.miss_detected) begin
                            base <= aligned_miss;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (issue_fire && (issue_cnt == LAST_WORD)) begin
                        issue_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded straight from registered state and memory inputs.
    always_comb begin
        bus.fsm_busy         = in_fill;
        bus.memory_req       = issue_fire;
        bus.memory_address   = '0;
        bus.write_data_array = recv_fire;
        bus.fill_data        = '0;
        bus.fill_word        = '0;
        bus.write_tag_array  = last_recv;
        if (issue_fire) begin
            bus.memory_address = base + ADDR_W'({issue_cnt, 1'b0});
        end
        if (recv_fire) begin
            bus.fill_data = bus.memory_data;
            bus.fill_word = recv_cnt;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_cache_fill_fsm;

    localparam int WPB = 8;
    localparam int AW  = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   tag_seen;
    int   req_seen;

    cache_fill_fsm_if #(.WORDS_PER_BLOCK(WPB), .ADDR_W(AW)) bus ();

    cache_fill_fsm #(.WORDS_PER_BLOCK(WPB), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: is a fill active, its base, words requested, words received.
    bit          m_fill, n_fill;
    logic [15:0] m_base, n_base;
    int          m_issued, n_issued;
    int          m_recv, n_recv;

    always @(negedge clk) begin
        bit          e_req, e_wr, e_tag;
        logic [15:0] e_addr, e_fd;
        int          e_fw;
        e_req  = m_fill && (m_issued < WPB);
        e_addr = e_req ? 16'(m_base + 16'(2 * m_issued)) : 16'h0;
        e_wr   = m_fill && bus.memory_data_valid;
        e_fd   = e_wr ? bus.memory_data : 16'h0;
        e_fw   = e_wr ? m_recv : 0;
        e_tag  = e_wr && (m_recv == WPB - 1);
        chk("m_busy", 32'(bus.fsm_busy), 32'(m_fill));
        chk("m_req", 32'(bus.memory_req), 32'(e_req));
        chk("m_addr", 32'(bus.memory_address), 32'(e_addr));
        chk("m_wr", 32'(bus.write_data_array), 32'(e_wr));
        chk("m_fdata", 32'(bus.fill_data), 32'(e_fd));
        chk("m_fword", 32'(bus.fill_word), 32'(e_fw));
        chk("m_tag", 32'(bus.write_tag_array), 32'(e_tag));
        if (bus.write_tag_array) tag_seen++;
        if (bus.memory_req) req_seen++;
        n_fill = m_fill; n_base = m_base; n_issued = m_issued; n_recv = m_recv;
        if (rst) begin
            n_fill = 0; n_base = 0; n_issued = 0; n_recv = 0;
        end else if (!m_fill) begin
            if (bus.miss_detected) begin
                n_fill = 1; n_base = bus.miss_address & 16'hFFF0; n_issued = 0; n_recv = 0;
            end
        end else begin
            if (e_req) n_issued = m_issued + 1;
            if (e_wr) n_recv = m_recv + 1;
            if (e_tag) begin
                n_issued = 0; n_recv = 0;
                if (bus.miss_detected) n_base = bus.miss_address & 16'hFFF0;
                else n_fill = 0;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fill <= 0; m_base <= '0; m_issued <= 0; m_recv <= 0;
        end else begin
            m_fill <= n_fill; m_base <= n_base; m_issued <= n_issued; m_recv <= n_recv;
        end
    end

    // One cycle of stimulus: drive after the edge, return at the sampling point.
    task automatic step(input bit miss, input logic [15:0] maddr, input bit vld, input logic [15:0] data);
        @(posedge clk);
        #1;
        bus.miss_detected     = miss;
        bus.miss_address      = maddr;
        bus.memory_data_valid = vld;
        bus.memory_data       = data;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 16'h0);
    endtask

    initial begin
        int tag0, req0, tag_before;
        checks = 0; failures = 0; tag_seen = 0; req_seen = 0;
        bus.miss_detected = 0; bus.miss_address = '0;
        bus.memory_data_valid = 0; bus.memory_data = '0;
        rst = 1'b1;
        #2;
        // Reset state, checked before any clock edge.
        chk("rst_busy", 32'(bus.fsm_busy), 0);
        chk("rst_req", 32'(bus.memory_req), 0);
        chk("rst_addr", 32'(bus.memory_address), 0);
        chk("rst_wr", 32'(bus.write_data_array), 0);
        chk("rst_tag", 32'(bus.write_tag_array), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Basic fill, data returns three cycles after each request.
        step(1, 16'h1236, 0, 16'h0);
        chk("t1_busy_first", 32'(bus.fsm_busy), 0);
        for (int c = 1; c <= 12; c++) begin
            bit v;
            v = (c >= 4) && (c <= 11);
            step(0, 16'h0, v, 16'(16'hA000 + c));
            chk("t1_busy", 32'(bus.fsm_busy), 32'(c <= 11));
            chk("t1_req", 32'(bus.memory_req), 32'(c <= 8));
            chk("t1_addr", 32'(bus.memory_address), (c <= 8) ? 32'(16'h1230 + 2 * (c - 1)) : 0);
            chk("t1_wr", 32'(bus.write_data_array), 32'(v));
            chk("t1_fword", 32'(bus.fill_word), v ? 32'(c - 4) : 0);
            chk("t1_fdata", 32'(bus.fill_data), v ? 32'(16'hA000 + c) : 0);
            chk("t1_tag", 32'(bus.write_tag_array), 32'(c == 11));
        end
        idle(2);

        // Gapped returns on alternate cycles.
        req0 = req_seen; tag0 = tag_seen;
        step(1, 16'h2468, 0, 16'h0);
        for (int c = 1; c <= 18; c++) begin
            bit v;
            v = (c % 2 == 0) && (c <= 16);
            step(0, 16'h0, v, 16'(16'h5000 + c));
            chk("t2_req", 32'(bus.memory_req), 32'(c <= 8));
            chk("t2_fword", 32'(bus.fill_word), v ? 32'(c / 2 - 1) : 0);
            chk("t2_tag", 32'(bus.write_tag_array), 32'(c == 16));
            chk("t2_busy", 32'(bus.fsm_busy), 32'(c <= 16));
        end
        idle(2);
        chk("t2_req_total", 32'(req_seen - req0), 8);
        chk("t2_tag_total", 32'(tag_seen - tag0), 1);

        // Top of memory; final issue and final return in the same cycle.
        step(1, 16'hFFFF, 0, 16'h0);
        for (int c = 1; c <= 9; c++) begin
            step(0, 16'h0, c <= 8, 16'(16'h0F00 + c));
            chk("t3_addr", 32'(bus.memory_address), (c <= 8) ? 32'(16'hFFF0 + 2 * (c - 1)) : 0);
            chk("t3_tag", 32'(bus.write_tag_array), 32'(c == 8));
            chk("t3_busy", 32'(bus.fsm_busy), 32'(c <= 8));
        end
        idle(1);

        // Spurious valid in IDLE, then a second miss during a fill.
        for (int i = 0; i < 3; i++) begin
            step(0, 16'h0, 1, 16'hDEAD);
            chk("t4_idle_wr", 32'(bus.write_data_array), 0);
            chk("t4_idle_fdata", 32'(bus.fill_data), 0);
        end
        step(1, 16'h3000, 0, 16'h0);
        for (int c = 1; c <= 10; c++) begin
            step((c >= 2) && (c <= 4), 16'h4000, c >= 3, 16'(16'h3300 + c));
            chk("t4_addr", 32'(bus.memory_address), (c <= 8) ? 32'(16'h3000 + 2 * (c - 1)) : 0);
            chk("t4_tag", 32'(bus.write_tag_array), 32'(c == 10));
        end
        idle(2);

        // Back-to-back misses: new miss in the tag cycle.
        step(1, 16'h5000, 0, 16'h0);
        for (int c = 1; c <= 8; c++) step(c == 8, 16'h6002, 1, 16'(16'h5500 + c));
        chk("t5_tag", 32'(bus.write_tag_array), 1);
        step(0, 16'h0, 0, 16'h0);
        chk("t5_busy", 32'(bus.fsm_busy), 1);
        chk("t5_req", 32'(bus.memory_req), 1);
        chk("t5_addr", 32'(bus.memory_address), 32'h6000);
        for (int c = 0; c < 8; c++) step(0, 16'h0, 1, 16'(16'h6600 + c));
        step(0, 16'h0, 0, 16'h0);
        chk("t5_done", 32'(bus.fsm_busy), 0);
        idle(1);

        // Reset pulsed after three words received.
        step(1, 16'h7000, 0, 16'h0);
        for (int c = 1; c <= 3; c++) step(0, 16'h0, 1, 16'(16'h7700 + c));
        @(posedge clk);
        #1;
        tag_before = tag_seen;
        bus.memory_data_valid = 1;
        rst = 1'b1;
        #1;
        chk("t6_busy", 32'(bus.fsm_busy), 0);
        chk("t6_req", 32'(bus.memory_req), 0);
        chk("t6_addr", 32'(bus.memory_address), 0);
        chk("t6_wr", 32'(bus.write_data_array), 0);
        chk("t6_fword", 32'(bus.fill_word), 0);
        chk("t6_tag", 32'(bus.write_tag_array), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.memory_data_valid = 0;
        idle(2);
        chk("t6_no_tag", 32'(tag_seen - tag_before), 0);
        step(1, 16'h7000, 0, 16'h0);
        step(0, 16'h0, 1, 16'h7A00);
        chk("t6_clean_fword", 32'(bus.fill_word), 0);
        chk("t6_clean_addr", 32'(bus.memory_address), 32'h7000);
        for (int c = 1; c < 8; c++) step(0, 16'h0, 1, 16'(16'h7A00 + c));
        chk("t6_clean_tag", 32'(bus.write_tag_array), 1);
        idle(2);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                @(posedge clk);
                #1 rst = 1'b0;
            end
            step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 1) == 1, 16'($urandom));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
